exec_arbiter: RTL and testbench
===============================

Name: exec_arbiter

Overview:
- Shares the single combinational execute unit (ALU/branch-compare) between two requesters: port 0 is the main pipeline and port 1 is the address/branch-target helper.
- Arbitrates between the two requesters and registers the winning operation into an issue stage that drives the execute unit.
- Captures the execute unit's result and returns it to the originating requester.
- Sits between decode/issue and the execute unit.
- Sustains one operation per cycle.
- Fixed latency of 2 cycles from acceptance to response.

Parameters:
- REGISTER_WIDTH, 32, operand/result width.
- ALU_CTRL_WIDTH, 5, execute-unit operation code width; the MSB selects the branch/JALR/LUI group.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  ALU_CTRL_WIDTH  port 0 operation code.
- req0_a  in  REGISTER_WIDTH  port 0 operand 1.
- req0_b  in  REGISTER_WIDTH  port 0 operand 2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for port 1.
- flush0  in  1  kills all port-0 work, in flight or requesting.
- alu_op  out  ALU_CTRL_WIDTH  to execute unit.
- alu_a  out  REGISTER_WIDTH  to execute unit.
- alu_b  out  REGISTER_WIDTH  to execute unit.
- alu_out  in  REGISTER_WIDTH  execute-unit result (combinational from alu_*).
- alu_bcond  in  1  execute-unit branch condition.
- resp0_valid  out  1  one-cycle pulse; result for port 0.
- resp1_valid  out  1  one-cycle pulse; result for port 1.
- resp_out  out  REGISTER_WIDTH  result, shared by both ports.
- resp_bcond  out  1  branch condition, shared by both ports.
- busy  out  1  issue or response stage holds a live op.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Issue stage (S1) and response stage (S2) valid bits cleared.
  - alu_op/alu_a/alu_b = 0; resp_out = 0; resp_bcond = 0; resp0_valid = resp1_valid = 0.
  - last_grant = 1, so port 0 wins the first contended cycle.
  - Reset mid-operation discards all in-flight ops; no response is ever produced for them.
- Grant (combinational, one cycle):
  - g0 = req0_valid & ~flush0 & (~req1_valid | ~RR_EN | last_grant==1).
  - g1 = req1_valid & ~g0.
  - req0_ready = g0; req1_ready = g1; at most one is high in any cycle.
  - Transfer occurs on valid & ready. Requesters must hold op and operands stable until accepted.
  - No backpressure from the response side; acceptance depends only on the grant.
- last_grant updates only on a transfer: 0 after a port-0 transfer, 1 after a port-1 transfer. Idle cycles leave it unchanged.
- Cycle N, transfer: S1 captures {op, a, b, src}, S1 valid = 1. With no transfer, S1 valid = 0; alu_* hold their last values (no toggling).
- Cycle N+1: alu_* are driven from S1. At the edge, S2 captures alu_out, alu_bcond, src, and valid.
- Cycle N+2: resp<src>_valid = 1 for exactly one cycle, with resp_out/resp_bcond from S2. resp_out/resp_bcond hold their value when no response is valid.
- Back-to-back transfers give back-to-back responses in acceptance order. Total latency is exactly 2 cycles.
- flush0 high in a cycle:
  - g0 is forced to 0 that cycle.
  - Any S1 or S2 entry with src = 0 has its valid cleared at the edge, so resp0_valid never fires for it.
  - Port-1 entries are unaffected. Port 1 may be granted the same cycle.
- busy = S1 valid | S2 valid.
- Data passes through unmodified, so arithmetic width is REGISTER_WIDTH end to end. Op codes are not decoded here.

Test Plan:
- Port 0 only, op=0x00 (ADD), a=5, b=7, accepted in cycle 1 -> req0_ready=1 in cycle 1; resp0_valid=1 with resp_out=12 in cycle 3; resp1_valid=0 throughout.
- Both ports valid continuously for 4 cycles after reset, port 0 ADD 1+1 and port 1 SUB 9-4 -> grants alternate 0,1,0,1; responses alternate resp0 (2) and resp1 (5) starting in cycle 3, one per cycle.
- RR_EN=0, both valid for 3 cycles -> port 0 granted every cycle; req1_ready stays 0.
- Port 1 branch op 0x14 (BLT), a=0xFFFFFFFF, b=1 -> resp1_valid pulses 2 cycles after acceptance with resp_bcond=1.
- Port 0 ADD accepted in cycle 1, flush0 high in cycle 2 while port 1 is granted -> no resp0_valid in cycle 3; port 1 response arrives in cycle 4.
- rst_n dropped for 1 cycle between acceptance and response -> no resp*_valid; after release, busy=0 and the first contended grant goes to port 0.

Source files
------------

// File: rtl/exec_arbiter_if.sv
// Request/response bundle between the two requesters and exec_arbiter.
// master = requester side, slave = arbiter side.
interface exec_arbiter_if #(
    parameter int REGISTER_WIDTH = 32,
    parameter int ALU_CTRL_WIDTH = 5
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic [ALU_CTRL_WIDTH-1:0] req0_op;
    logic [REGISTER_WIDTH-1:0] req0_a;
    logic [REGISTER_WIDTH-1:0] req0_b;
    logic                      req1_valid;
    logic                      req1_ready;
    logic [ALU_CTRL_WIDTH-1:0] req1_op;
    logic [REGISTER_WIDTH-1:0] req1_a;
    logic [REGISTER_WIDTH-1:0] req1_b;
    logic                      flush0;
    logic                      resp0_valid;
    logic                      resp1_valid;
    logic [REGISTER_WIDTH-1:0] resp_out;
    logic                      resp_bcond;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output flush0,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_out, resp_bcond
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  flush0,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_out, resp_bcond
    );
endinterface

// File: rtl/exec_arbiter.sv
// Two-port arbiter in front of the shared execute unit.
// Issue stage (S1) drives the unit, response stage (S2) returns results.
module exec_arbiter #(
    parameter int REGISTER_WIDTH = 32,
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int RR_EN          = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    exec_arbiter_if.slave             req,
    output logic [ALU_CTRL_WIDTH-1:0] alu_op,
    output logic [REGISTER_WIDTH-1:0] alu_a,
    output logic [REGISTER_WIDTH-1:0] alu_b,
    input  logic [REGISTER_WIDTH-1:0] alu_out,
    input  logic                      alu_bcond,
    output logic                      busy
);
    localparam logic RR = (RR_EN != 0);

    logic g0;
    logic g1;
    logic last_grant;
    logic s1_valid;
    logic s1_src;
    logic s2_valid;
    logic s2_src;
    logic s1_kill;
    logic s2_load;
    logic xfer;

    // Grant: port 0 wins unless port 1 is owed a turn or port 0 is flushed.
    always_comb begin
        g0 = req.req0_valid & ~req.flush0
           & (~req.req1_valid | ~RR | last_grant);
        g1 = req.req1_valid & ~g0;
    end

    assign req.req0_ready = g0;
    assign req.req1_ready = g1;
    assign xfer    = g0 | g1;
    assign s1_kill = req.flush0 & ~s1_src;
    assign s2_load = s1_valid & ~s1_kill;

    // Round-robin pointer moves only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= g1;
        end
    end

    // Issue stage: alu_* are the S1 payload and hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_src   <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_src <= g1;
                alu_op <= g1 ? req.req1_op : req.req0_op;
                alu_a  <= g1 ? req.req1_a  : req.req0_a;
                alu_b  <= g1 ? req.req1_b  : req.req0_b;
            end
        end
    end

    // Response stage: capture unit result unless the op was flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            s2_src         <= 1'b0;
            req.resp_out   <= '0;
            req.resp_bcond <= 1'b0;
        end else begin
            s2_valid <= s2_load;
            if (s2_load) begin
                s2_src         <= s1_src;
                req.resp_out   <= alu_out;
                req.resp_bcond <= alu_bcond;
            end
        end
    end

    // Response pulses are steered to the originating port.
    always_comb begin
        req.resp0_valid = s2_valid & ~s2_src;
        req.resp1_valid = s2_valid & s2_src;
        busy            = s1_valid | s2_valid;
    end
endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter with a small behavioural execute unit.
// Second instance runs with fixed priority.
module tb_exec_arbiter;
    localparam int W  = 32;
    localparam int OW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exec_arbiter_if #(.REGISTER_WIDTH(W), .ALU_CTRL_WIDTH(OW)) ifa ();
    exec_arbiter_if #(.REGISTER_WIDTH(W), .ALU_CTRL_WIDTH(OW)) ifb ();

    logic [OW-1:0] a_op, b_op;
    logic [W-1:0]  a_a, a_b, a_out, b_a, b_b, b_out;
    logic          a_bc, b_bc, a_busy, b_busy;

    // Execute unit stand-in: 0=ADD, 1=SUB, 0x14=BLT (signed).
    function automatic logic [W:0] alu_f(input logic [OW-1:0] op,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         c;
        r = (op == 5'h01) ? x - y : x + y;
        c = (op == 5'h14) ? ($signed(x) < $signed(y)) : 1'b0;
        return {c, r};
    endfunction

    assign {a_bc, a_out} = alu_f(a_op, a_a, a_b);
    assign {b_bc, b_out} = alu_f(b_op, b_a, b_b);

    exec_arbiter #(.REGISTER_WIDTH(W), .ALU_CTRL_WIDTH(OW), .RR_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(ifa.slave),
        .alu_op(a_op), .alu_a(a_a), .alu_b(a_b),
        .alu_out(a_out), .alu_bcond(a_bc), .busy(a_busy)
    );

    exec_arbiter #(.REGISTER_WIDTH(W), .ALU_CTRL_WIDTH(OW), .RR_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(ifb.slave),
        .alu_op(b_op), .alu_a(b_a), .alu_b(b_b),
        .alu_out(b_out), .alu_bcond(b_bc), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.req0_valid = 0; ifa.req0_op = 0; ifa.req0_a = 0; ifa.req0_b = 0;
        ifa.req1_valid = 0; ifa.req1_op = 0; ifa.req1_a = 0; ifa.req1_b = 0;
        ifa.flush0 = 0;
        ifb.req0_valid = 0; ifb.req0_op = 0; ifb.req0_a = 0; ifb.req0_b = 0;
        ifb.req1_valid = 0; ifb.req1_op = 0; ifb.req1_a = 0; ifb.req1_b = 0;
        ifb.flush0 = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #2;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        idle();
        #2;
        // reset values
        check("rst_alu_a", a_a, 0);
        check("rst_alu_op", {27'd0, a_op}, 0);
        check("rst_resp_out", ifa.resp_out, 0);
        check("rst_resp0", {31'd0, ifa.resp0_valid}, 0);
        check("rst_resp1", {31'd0, ifa.resp1_valid}, 0);
        check("rst_busy", {31'd0, a_busy}, 0);
        do_reset();

        // single port-0 ADD
        ifa.req0_valid = 1; ifa.req0_op = 5'h00;
        ifa.req0_a = 5; ifa.req0_b = 7;
        #2;
        check("t1_rdy0", {31'd0, ifa.req0_ready}, 1);
        check("t1_rdy1", {31'd0, ifa.req1_ready}, 0);
        step();
        ifa.req0_valid = 0;
        #2;
        check("t1_c2_resp0", {31'd0, ifa.resp0_valid}, 0);
        check("t1_c2_alu_a", a_a, 5);
        check("t1_c2_busy", {31'd0, a_busy}, 1);
        step();
        #2;
        check("t1_c3_resp0", {31'd0, ifa.resp0_valid}, 1);
        check("t1_c3_resp1", {31'd0, ifa.resp1_valid}, 0);
        check("t1_c3_out", ifa.resp_out, 12);
        step();
        #2;
        check("t1_c4_resp0", {31'd0, ifa.resp0_valid}, 0);
        check("t1_c4_hold", ifa.resp_out, 12);
        check("t1_c4_alu_hold", a_a, 5);
        check("t1_c4_busy", {31'd0, a_busy}, 0);
        step();

        // round-robin alternation
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                ifa.req0_valid = 1; ifa.req0_op = 5'h00;
                ifa.req0_a = 1; ifa.req0_b = 1;
                ifa.req1_valid = 1; ifa.req1_op = 5'h01;
                ifa.req1_a = 9; ifa.req1_b = 4;
            end else begin
                idle();
            end
            #2;
            if (c <= 4) begin
                check($sformatf("rr_rdy0_c%0d", c),
                      {31'd0, ifa.req0_ready}, c % 2);
                check($sformatf("rr_rdy1_c%0d", c),
                      {31'd0, ifa.req1_ready}, 1 - (c % 2));
            end
            if (c >= 3) begin
                check($sformatf("rr_resp0_c%0d", c),
                      {31'd0, ifa.resp0_valid}, c % 2);
                check($sformatf("rr_resp1_c%0d", c),
                      {31'd0, ifa.resp1_valid}, 1 - (c % 2));
                check($sformatf("rr_out_c%0d", c),
                      ifa.resp_out, (c % 2) ? 2 : 5);
            end
            step();
        end

        // fixed priority instance
        for (int c = 1; c <= 3; c++) begin
            ifb.req0_valid = 1; ifb.req0_a = c; ifb.req0_b = 0;
            ifb.req1_valid = 1; ifb.req1_a = 9; ifb.req1_b = 0;
            #2;
            check($sformatf("fp_rdy0_c%0d", c), {31'd0, ifb.req0_ready}, 1);
            check($sformatf("fp_rdy1_c%0d", c), {31'd0, ifb.req1_ready}, 0);
            step();
        end
        idle();
        step();
        step();

        // port-1 BLT
        ifa.req1_valid = 1; ifa.req1_op = 5'h14;
        ifa.req1_a = 32'hFFFF_FFFF; ifa.req1_b = 1;
        #2;
        check("blt_rdy1", {31'd0, ifa.req1_ready}, 1);
        step();
        idle();
        step();
        #2;
        check("blt_resp1", {31'd0, ifa.resp1_valid}, 1);
        check("blt_resp0", {31'd0, ifa.resp0_valid}, 0);
        check("blt_bcond", {31'd0, ifa.resp_bcond}, 1);
        step();

        // flush of in-flight port-0 op
        do_reset();
        ifa.req0_valid = 1; ifa.req0_op = 5'h00;
        ifa.req0_a = 3; ifa.req0_b = 4;
        #2;
        check("fl_rdy0_c1", {31'd0, ifa.req0_ready}, 1);
        step();
        ifa.req0_a = 20; ifa.req0_b = 20;
        ifa.req1_valid = 1; ifa.req1_op = 5'h01;
        ifa.req1_a = 10; ifa.req1_b = 3;
        ifa.flush0 = 1;
        #2;
        check("fl_rdy0_c2", {31'd0, ifa.req0_ready}, 0);
        check("fl_rdy1_c2", {31'd0, ifa.req1_ready}, 1);
        step();
        idle();
        #2;
        check("fl_resp0_c3", {31'd0, ifa.resp0_valid}, 0);
        check("fl_resp1_c3", {31'd0, ifa.resp1_valid}, 0);
        step();
        #2;
        check("fl_resp1_c4", {31'd0, ifa.resp1_valid}, 1);
        check("fl_resp0_c4", {31'd0, ifa.resp0_valid}, 0);
        check("fl_out_c4", ifa.resp_out, 7);
        step();

        // reset mid-flight
        do_reset();
        ifa.req0_valid = 1; ifa.req0_a = 2; ifa.req0_b = 2;
        #2;
        check("mr_rdy0", {31'd0, ifa.req0_ready}, 1);
        step();
        ifa.req0_valid = 0;
        rst_n = 0;
        #2;
        check("mr_busy_rst", {31'd0, a_busy}, 0);
        step();
        rst_n = 1;
        #2;
        check("mr_resp0", {31'd0, ifa.resp0_valid}, 0);
        check("mr_resp1", {31'd0, ifa.resp1_valid}, 0);
        check("mr_busy", {31'd0, a_busy}, 0);
        step();
        #2;
        check("mr_resp0_b", {31'd0, ifa.resp0_valid}, 0);
        step();
        ifa.req0_valid = 1; ifa.req1_valid = 1;
        #2;
        check("mr_grant0", {31'd0, ifa.req0_ready}, 1);
        check("mr_grant1", {31'd0, ifa.req1_ready}, 0);
        step();
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
